fetch_sequencer: RTL and testbench

- Controls instruction fetch for the pipelined MIPS core.
- Owns the PC register and drives a multi-cycle instruction memory through a req/ready handshake.
- Loads the IF/ID register and applies hazard stalls, ID-stage branch/jump redirects (delay-slot correct), and exception/ERET redirects.
- Sits between the hazard/branch/CP0 logic and the instruction memory.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/fetch_hold_buf.sv | 45 ++++
 rtl/fetch_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS instruction-fetch front end.
package mips_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [XLEN-1:0] EXC_VEC_DEF  = 32'h0000_4180;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry skid buffer that parks a completed fetch while IF/ID is stalled.
module fetch_hold_buf
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       drain,
  input  logic       clear,
  input  fetch_pkt_t load_pkt,
  output logic       valid,
  output fetch_pkt_t pkt
);

  logic       valid_q, valid_d;
  fetch_pkt_t pkt_q, pkt_d;

  always_comb begin
    valid_d = valid_q;
    pkt_d   = pkt_q;
    if (clear) begin
      valid_d = 1'b0;
      pkt_d   = '0;
    end else if (load) begin
      valid_d = 1'b1;
      pkt_d   = load_pkt;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pkt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pkt_q   <= pkt_d;
    end
  end

  assign valid = valid_q;
  assign pkt   = pkt_q;

endmodule

// File: rtl/fetch_sequencer.sv
// PC owner and instruction-fetch controller feeding the IF/ID register.
// Optional misaligned-PC trap enabled by defining PC_ALIGN_CHK_EN.
module fetch_sequencer
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] EXC_VEC  = EXC_VEC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redir_valid,
  input  logic [XLEN-1:0]    redir_target,
  input  logic               exc_valid,
  input  logic               eret_valid,
  input  logic [XLEN-1:0]    epc,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [XLEN-1:0]    if_pc,
`ifdef PC_ALIGN_CHK_EN
  output logic               if_adel,
`endif
  output logic [XLEN-1:0]    if_pc4
);

  fetch_state_e       state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic               pend_valid_q, pend_valid_d;
  logic [XLEN-1:0]    pend_target_q, pend_target_d;
  logic               if_valid_q, if_valid_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic [XLEN-1:0]    if_pc_q, if_pc_d;

  logic               flush;
  logic [XLEN-1:0]    flush_tgt;
  logic [XLEN-1:0]    npc;
  logic               hb_load, hb_drain, hb_clear, hb_valid;
  fetch_pkt_t         hb_load_pkt, hb_pkt;
  logic               fetch_ok;

`ifdef PC_ALIGN_CHK_EN
  logic               if_adel_q, if_adel_d;
  logic               misalign;
  assign misalign = (pc_q[1:0] != 2'b00);
  assign fetch_ok = !misalign;
`else
  assign fetch_ok = 1'b1;
`endif

  assign flush       = exc_valid | eret_valid;
  assign flush_tgt   = exc_valid ? EXC_VEC : epc;
  assign npc         = pend_valid_q ? pend_target_q : pc_q + XLEN'(4);
  assign hb_load_pkt = '{instr: imem_rdata, pc: pc_q};

  fetch_hold_buf u_hold_buf (
    .clk      (clk),
    .reset    (reset),
    .load     (hb_load),
    .drain    (hb_drain),
    .clear    (hb_clear),
    .load_pkt (hb_load_pkt),
    .valid    (hb_valid),
    .pkt      (hb_pkt)
  );

  // Next-state, PC and IF/ID update
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    hb_load       = 1'b0;
    hb_drain      = 1'b0;
    hb_clear      = 1'b0;
`ifdef PC_ALIGN_CHK_EN
    if_adel_d     = if_adel_q;
`endif

    unique case (state_q)
      ST_FETCH: begin
        if (flush) begin
          if_valid_d = 1'b0;
          hb_clear   = 1'b1;
`ifdef PC_ALIGN_CHK_EN
          if_adel_d  = 1'b0;
`endif
          if (imem_ready || !fetch_ok) begin
            pc_d         = flush_tgt;
            pend_valid_d = 1'b0;
          end else begin
            pend_target_d = flush_tgt;
            pend_valid_d  = 1'b1;
            state_d       = ST_DRAIN;
          end
        end else if (!fetch_ok) begin
          // Misaligned PC: deliver a faulting bubble and park until a flush
          if (!stall) begin
            if_valid_d = 1'b1;
            if_instr_d = '0;
            if_pc_d    = pc_q;
`ifdef PC_ALIGN_CHK_EN
            if_adel_d  = 1'b1;
`endif
          end
        end else if (imem_ready) begin
          pend_valid_d = 1'b0;
          pc_d         = npc;
          if (!stall) begin
            if_valid_d = 1'b1;
            if_instr_d = imem_rdata;
            if_pc_d    = pc_q;
`ifdef PC_ALIGN_CHK_EN
            if_adel_d  = 1'b0;
`endif
            // Completing fetch is the delay slot; redirect takes effect next
            if (redir_valid) pc_d = redir_target;
          end else begin
            hb_load = 1'b1;
            state_d = ST_HOLD;
          end
        end else if (!stall) begin
          if_valid_d = 1'b0;
          if (redir_valid) begin
            pend_target_d = redir_target;
            pend_valid_d  = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        if (flush) begin
          if_valid_d   = 1'b0;
          hb_clear     = 1'b1;
          pc_d         = flush_tgt;
          pend_valid_d = 1'b0;
          state_d      = ST_FETCH;
`ifdef PC_ALIGN_CHK_EN
          if_adel_d    = 1'b0;
`endif
        end else if (!stall) begin
          if_valid_d = hb_valid;
          if_instr_d = hb_pkt.instr;
          if_pc_d    = hb_pkt.pc;
          hb_drain   = 1'b1;
          state_d    = ST_FETCH;
`ifdef PC_ALIGN_CHK_EN
          if_adel_d  = 1'b0;
`endif
          if (redir_valid) pc_d = redir_target;
        end
      end

      ST_DRAIN: begin
        if_valid_d = 1'b0;
        if (flush) pend_target_d = flush_tgt;
        if (imem_ready) begin
          pc_d         = flush ? flush_tgt : pend_target_q;
          pend_valid_d = 1'b0;
          state_d      = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      if_valid_q    <= 1'b0;
      if_instr_q    <= '0;
      if_pc_q       <= '0;
`ifdef PC_ALIGN_CHK_EN
      if_adel_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
`ifdef PC_ALIGN_CHK_EN
      if_adel_q     <= if_adel_d;
`endif
    end
  end

  // DRAIN keeps presenting the abandoned address until imem completes it
  assign imem_req  = !reset && (((state_q == ST_FETCH) && fetch_ok) || (state_q == ST_DRAIN));
  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign if_pc4    = if_pc_q + XLEN'(4);
`ifdef PC_ALIGN_CHK_EN
  assign if_adel   = if_adel_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; imem data = addr ^ KEY.
module tb_fetch_sequencer;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset, stall, redir_valid, exc_valid, eret_valid, imem_ready;
  logic [31:0] redir_target, epc, imem_rdata;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_instr, if_pc, if_pc4;
`ifdef PC_ALIGN_CHK_EN
  logic        if_adel;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .exc_valid    (exc_valid),
    .eret_valid   (eret_valid),
    .epc          (epc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
`ifdef PC_ALIGN_CHK_EN
    .if_adel      (if_adel),
`endif
    .if_pc4       (if_pc4)
  );

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge
  task automatic cyc(input logic rdy, input logic stl, input logic rv, input logic [31:0] rt,
                     input logic ex, input logic er, input logic [31:0] ep);
    imem_ready   = rdy;
    imem_rdata   = rdy ? (imem_addr ^ KEY) : 32'hDEAD_BEEF;
    stall        = stl;
    redir_valid  = rv;
    redir_target = rt;
    exc_valid    = ex;
    eret_valid   = er;
    epc          = ep;
    @(posedge clk);
    #1;
    imem_ready = 1'b0; stall = 1'b0; redir_valid = 1'b0; exc_valid = 1'b0; eret_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; redir_valid = 1'b0; redir_target = '0; exc_valid = 1'b0;
    eret_valid = 1'b0; epc = '0; imem_ready = 1'b0; imem_rdata = '0;
    @(posedge clk); #1;
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b exp 0", imem_req); end
    n_chk++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", if_valid); end
    n_chk++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h exp 0", if_pc); end
    n_chk++; if (if_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h exp 0", if_instr); end
    reset = 1'b0; #1;
    n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL post_reset_req: got %b exp 1", imem_req); end
    n_chk++; if (imem_addr !== 32'h3000) begin n_fail++; $display("FAIL post_reset_addr: got %h exp 3000", imem_addr); end
  endtask

  task automatic test_streaming();
    cyc(1, 0, 0, 0, 0, 0, 0);
    n_chk++; if (if_valid !== 1'b1 || if_pc !== 32'h3000 || if_instr !== (32'h3000 ^ KEY)) begin n_fail++; $display("FAIL stream0: got v=%b pc=%h i=%h exp pc 3000", if_valid, if_pc, if_instr); end
    n_chk++; if (imem_addr !== 32'h3004) begin n_fail++; $display("FAIL stream0_addr: got %h exp 3004", imem_addr); end
    cyc(1, 0, 0, 0, 0, 0, 0);
    n_chk++; if (if_pc !== 32'h3004 || imem_addr !== 32'h3008) begin n_fail++; $display("FAIL stream1: got pc=%h addr=%h exp 3004/3008", if_pc, imem_addr); end
    cyc(1, 0, 0, 0, 0, 0, 0);
    n_chk++; if (if_pc !== 32'h3008 || imem_addr !== 32'h300C || if_pc4 !== 32'h300C) begin n_fail++; $display("FAIL stream2: got pc=%h addr=%h pc4=%h exp 3008/300c/300c", if_pc, imem_addr, if_pc4); end
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      n_chk++; if (if_valid !== 1'b0 || imem_addr !== 32'h300C || imem_req !== 1'b1) begin n_fail++; $display("FAIL wait%0d: got v=%b addr=%h req=%b exp 0/300c/1", i, if_valid, imem_addr, imem_req); end
    end
    cyc(1, 0, 0, 0, 0, 0, 0);
    n_chk++; if (if_valid !== 1'b1 || if_pc !== 32'h300C || if_instr !== (32'h300C ^ KEY) || imem_addr !== 32'h3010) begin n_fail++; $display("FAIL wait_done: got v=%b pc=%h i=%h addr=%h exp pc 300c addr 3010", if_valid, if_pc, if_instr, imem_addr); end
  endtask

  task automatic test_redirect();
    cyc(0, 0, 1, 32'h3100, 0, 0, 0);
    n_chk++; if (if_valid !== 1'b0 || imem_addr !== 32'h3010) begin n_fail++; $display("FAIL redir_pend: got v=%b addr=%h exp 0/3010", if_valid, imem_addr); end
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    n_chk++; if (if_pc !== 32'h3010 || imem_addr !== 32'h3100) begin n_fail++; $display("FAIL redir_slot: got pc=%h addr=%h exp 3010/3100", if_pc, imem_addr); end
    cyc(1, 0, 1, 32'h3200, 0, 0, 0);
    n_chk++; if (if_pc !== 32'h3100 || imem_addr !== 32'h3200) begin n_fail++; $display("FAIL redir_ready: got pc=%h addr=%h exp 3100/3200", if_pc, imem_addr); end
  endtask

  task automatic test_stall_hold();
    cyc(1, 1, 0, 0, 0, 0, 0);
    n_chk++; if (imem_req !== 1'b0 || if_pc !== 32'h3100 || if_valid !== 1'b1) begin n_fail++; $display("FAIL hold_enter: got req=%b pc=%h v=%b exp 0/3100/1", imem_req, if_pc, if_valid); end
    cyc(0, 1, 0, 0, 0, 0, 0);
    n_chk++; if (imem_req !== 1'b0 || if_pc !== 32'h3100) begin n_fail++; $display("FAIL hold_stay: got req=%b pc=%h exp 0/3100", imem_req, if_pc); end
    cyc(0, 0, 0, 0, 0, 0, 0);
    n_chk++; if (if_pc !== 32'h3200 || if_instr !== (32'h3200 ^ KEY) || imem_req !== 1'b1 || imem_addr !== 32'h3204) begin n_fail++; $display("FAIL hold_release: got pc=%h i=%h req=%b addr=%h exp 3200/3204", if_pc, if_instr, imem_req, imem_addr); end
    cyc(1, 0, 0, 0, 0, 0, 0);
    n_chk++; if (if_pc !== 32'h3204 || imem_addr !== 32'h3208) begin n_fail++; $display("FAIL hold_next: got pc=%h addr=%h exp 3204/3208", if_pc, imem_addr); end
    cyc(0, 1, 0, 0, 0, 0, 0);
    n_chk++; if (if_valid !== 1'b1 || if_pc !== 32'h3204 || imem_addr !== 32'h3208) begin n_fail++; $display("FAIL stall_wait: got v=%b pc=%h addr=%h exp 1/3204/3208", if_valid, if_pc, imem_addr); end
  endtask

  task automatic test_exception();
    cyc(0, 0, 0, 0, 1, 0, 0);
    n_chk++; if (if_valid !== 1'b0 || imem_addr !== 32'h3208 || imem_req !== 1'b1) begin n_fail++; $display("FAIL exc_drain: got v=%b addr=%h req=%b exp 0/3208/1", if_valid, imem_addr, imem_req); end
    cyc(0, 0, 0, 0, 0, 0, 0);
    n_chk++; if (imem_addr !== 32'h3208) begin n_fail++; $display("FAIL exc_drain_hold: got %h exp 3208", imem_addr); end
    cyc(1, 0, 0, 0, 0, 0, 0);
    n_chk++; if (if_valid !== 1'b0 || imem_addr !== 32'h4180) begin n_fail++; $display("FAIL exc_dropped: got v=%b addr=%h exp 0/4180", if_valid, imem_addr); end
    cyc(1, 0, 0, 0, 0, 0, 0);
    n_chk++; if (if_valid !== 1'b1 || if_pc !== 32'h4180 || imem_addr !== 32'h4184) begin n_fail++; $display("FAIL exc_vec: got v=%b pc=%h addr=%h exp 1/4180/4184", if_valid, if_pc, imem_addr); end
  endtask

  task automatic test_exc_eret();
    cyc(1, 0, 0, 0, 1, 1, 32'h3050);
    n_chk++; if (if_valid !== 1'b0 || imem_addr !== 32'h4180) begin n_fail++; $display("FAIL exc_wins: got v=%b addr=%h exp 0/4180", if_valid, imem_addr); end
    cyc(1, 0, 0, 0, 0, 1, 32'h3050);
    n_chk++; if (if_valid !== 1'b0 || imem_addr !== 32'h3050) begin n_fail++; $display("FAIL eret: got v=%b addr=%h exp 0/3050", if_valid, imem_addr); end
    cyc(1, 0, 0, 0, 0, 0, 0);
    n_chk++; if (if_pc !== 32'h3050 || imem_addr !== 32'h3054) begin n_fail++; $display("FAIL eret_fetch: got pc=%h addr=%h exp 3050/3054", if_pc, imem_addr); end
  endtask

  task automatic test_flush_hold();
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 32'h3300);
    n_chk++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h3300) begin n_fail++; $display("FAIL flush_hold: got v=%b req=%b addr=%h exp 0/1/3300", if_valid, imem_req, imem_addr); end
    cyc(1, 0, 0, 0, 0, 0, 0);
    n_chk++; if (if_pc !== 32'h3300 || if_instr !== (32'h3300 ^ KEY) || imem_addr !== 32'h3304) begin n_fail++; $display("FAIL flush_hold_next: got pc=%h i=%h addr=%h exp 3300/3304", if_pc, if_instr, imem_addr); end
  endtask

  task automatic test_drain_last_flush();
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h3400);
    cyc(1, 0, 1, 32'h3500, 0, 0, 0);
    n_chk++; if (if_valid !== 1'b0 || imem_addr !== 32'h3400) begin n_fail++; $display("FAIL drain_last: got v=%b addr=%h exp 0/3400", if_valid, imem_addr); end
  endtask

  task automatic test_wrap();
    cyc(1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0, 0, 0, 0);
    n_chk++; if (if_pc !== 32'hFFFF_FFFC || if_pc4 !== 32'h0 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap: got pc=%h pc4=%h addr=%h exp fffffffc/0/0", if_pc, if_pc4, imem_addr); end
    cyc(1, 0, 0, 0, 0, 0, 0);
    n_chk++; if (if_pc !== 32'h0 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL wrap_next: got pc=%h addr=%h exp 0/4", if_pc, imem_addr); end
  endtask

  task automatic test_reset_mid();
    cyc(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h0) begin n_fail++; $display("FAIL reset_mid: got req=%b v=%b pc=%h exp 0/0/0", imem_req, if_valid, if_pc); end
    reset = 1'b0; #1;
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin n_fail++; $display("FAIL reset_mid_addr: got req=%b addr=%h exp 1/3000", imem_req, imem_addr); end
  endtask

`ifdef PC_ALIGN_CHK_EN
  task automatic test_align();
    cyc(1, 0, 1, 32'h3102, 0, 0, 0);
    n_chk++; if (if_pc !== 32'h3000 || if_adel !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h3102) begin n_fail++; $display("FAIL align_enter: got pc=%h adel=%b req=%b addr=%h exp 3000/0/0/3102", if_pc, if_adel, imem_req, imem_addr); end
    cyc(0, 0, 0, 0, 0, 0, 0);
    n_chk++; if (if_valid !== 1'b1 || if_adel !== 1'b1 || if_pc !== 32'h3102 || if_instr !== 32'h0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL align_adel: got v=%b adel=%b pc=%h i=%h req=%b exp 1/1/3102/0/0", if_valid, if_adel, if_pc, if_instr, imem_req); end
    cyc(0, 0, 0, 0, 1, 0, 0);
    n_chk++; if (if_valid !== 1'b0 || if_adel !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4180) begin n_fail++; $display("FAIL align_flush: got v=%b adel=%b req=%b addr=%h exp 0/0/1/4180", if_valid, if_adel, imem_req, imem_addr); end
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_wait_states();
    test_redirect();
    test_stall_hold();
    test_exception();
    test_exc_eret();
    test_flush_hold();
    test_drain_last_flush();
    test_wrap();
    test_reset_mid();
`ifdef PC_ALIGN_CHK_EN
    test_align();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
